// File: rtl/usrt_tx_if.sv
// Write-side handshake bundle for usrt_tx: one 28-bit frame word (four 7-bit characters)
// transferred on wr_en & rdy.
interface usrt_tx_if;
    logic [27:0] din;
    logic        wr_en;
    logic        rdy;

    modport master (output din, output wr_en, input rdy);
    modport slave  (input din, input wr_en, output rdy);
endinterface

// File: rtl/usrt_tx.sv
// usrt_tx: USRT transmit framer that turns the cntr slot index into the TXD line level.
// Optional macro USRT_TX_HOLD_EN adds a one-word hold buffer for gapless back-to-back frames.
module usrt_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_usrt,
    input  logic       RTS,
    input  logic       par_en,
    input  logic [5:0] cout,
    input  logic       max,
    usrt_tx_if.slave   wr,
    output logic       START,
    output logic       TXD,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, WAIT, ARM, SEND} state_t;

    state_t      r_state;
    logic [27:0] r_shift;
    logic        r_start;
    logic        r_txd;
    logic        r_done;

    logic        w_accept;
    logic        w_frameEnd;
    logic        w_slotLevel;
    logic [5:0]  w_charBase;
    logic [5:0]  w_slot;
    logic [6:0]  w_charBits;

`ifdef USRT_TX_HOLD_EN
    logic [27:0] r_hold;
    logic        r_holdFull;

    assign wr.rdy = !r_holdFull;
`else
    assign wr.rdy = (r_state == IDLE);
`endif

    assign w_accept   = wr.wr_en & wr.rdy;
    assign w_frameEnd = (r_state == SEND) & max & en_usrt;

    assign START = r_start;
    assign TXD   = r_txd;
    assign done  = r_done;
    assign busy  = (r_state != IDLE);

    // Split cout into character (tens) and slot-within-character, then pick the line level.
    always_comb begin
        w_charBase = 6'd0;
        w_charBits = r_shift[6:0];
        if (cout >= 6'd30) begin
            w_charBase = 6'd30;
            w_charBits = r_shift[27:21];
        end else if (cout >= 6'd20) begin
            w_charBase = 6'd20;
            w_charBits = r_shift[20:14];
        end else if (cout >= 6'd10) begin
            w_charBase = 6'd10;
            w_charBits = r_shift[13:7];
        end
        w_slot      = cout - w_charBase;
        w_slotLevel = 1'b1;
        case (w_slot)
            6'd0:                                    w_slotLevel = 1'b0;
            6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7: w_slotLevel = w_charBits[w_slot[2:0] - 3'd1];
            6'd8:                                    w_slotLevel = par_en ? ^w_charBits : 1'b1;
            default:                                 w_slotLevel = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_start <= 1'b0;
            r_txd   <= 1'b1;
            r_done  <= 1'b0;
`ifdef USRT_TX_HOLD_EN
            r_hold     <= '0;
            r_holdFull <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_txd   <= 1'b1;
                    r_start <= 1'b0;
                    if (w_accept) begin
                        r_shift <= wr.din;
                        r_state <= WAIT;
                    end
                end
                // Launching on a qualified tick makes the first start bit a full baud period.
                WAIT: begin
                    if (en_usrt & RTS) begin
                        r_state <= ARM;
                        r_start <= 1'b1;
                        r_txd   <= 1'b0;
                    end else begin
                        r_txd <= 1'b1;
                    end
                end
                ARM: begin
                    if (cout != 6'd0) begin
                        r_state <= SEND;
                        r_start <= 1'b0;
                        r_txd   <= w_slotLevel;
                    end else begin
                        r_start <= 1'b1;
                        r_txd   <= 1'b0;
                    end
                end
                SEND: begin
                    if (w_frameEnd) begin
                        r_done <= 1'b1;
`ifdef USRT_TX_HOLD_EN
                        // Chain straight into the next start bit on the counter-clear edge.
                        if (r_holdFull) begin
                            r_shift    <= r_hold;
                            r_holdFull <= 1'b0;
                            r_state    <= ARM;
                            r_start    <= 1'b1;
                            r_txd      <= 1'b0;
                        end else if (w_accept) begin
                            r_shift <= wr.din;
                            r_state <= ARM;
                            r_start <= 1'b1;
                            r_txd   <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_txd   <= 1'b1;
                        end
`else
                        r_state <= IDLE;
                        r_txd   <= 1'b1;
`endif
                    end else begin
                        r_txd <= w_slotLevel;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_start <= 1'b0;
                    r_txd   <= 1'b1;
                end
            endcase
`ifdef USRT_TX_HOLD_EN
            if (w_accept && (r_state != IDLE) && !w_frameEnd) begin
                r_hold     <= wr.din;
                r_holdFull <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_usrt_tx.sv
// tb_usrt_tx: randomized self-checking bench for usrt_tx driven by a behavioural cntr model.
// Each transmitted frame is captured one level per baud period and compared with a frame built from the character/parity rules.
module tb_usrt_tx;

    localparam int TICK_GAP = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_usrt = 1'b0;
    logic       RTS = 1'b1;
    logic       par_en = 1'b1;
    logic [5:0] cout;
    logic       max;
    logic       cntRun;
    logic       START;
    logic       TXD;
    logic       busy;
    logic       done;

    int compareCount = 0;
    int mismatchCount = 0;

    usrt_tx_if wrIf ();

    usrt_tx dut (
        .clk     (clk),
        .rst     (rst),
        .en_usrt (en_usrt),
        .RTS     (RTS),
        .par_en  (par_en),
        .cout    (cout),
        .max     (max),
        .wr      (wrIf),
        .START   (START),
        .TXD     (TXD),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Companion slot counter: starts on a sampled START, skips slot x8 without parity, clears after slot 39.
    always @(posedge clk) begin
        if (rst) begin
            cout   <= 6'd0;
            cntRun <= 1'b0;
        end else begin
            if (START) cntRun <= 1'b1;
            if (en_usrt && RTS && cntRun) begin
                if (cout == 6'd39) begin
                    cout   <= 6'd0;
                    cntRun <= 1'b0;
                end else if (!par_en && (int'(cout) % 10 == 7)) begin
                    cout <= cout + 6'd2;
                end else begin
                    cout <= cout + 6'd1;
                end
            end
        end
    end
    assign max = (cout == 6'd39);

    typedef struct {
        logic [63:0] bits;
        int          nBits;
        int          ticks;
        logic        txdAtDone;
        logic        startAtDone;
    } frameRec_t;

    frameRec_t   frames[$];
    logic [63:0] capBits = '0;
    int          capN = 0;
    int          capTicks = 0;
    bit          capturing = 1'b0;
    logic        lastBit = 1'b1;
    bit          lastQual = 1'b0;
    bit          sawTick = 1'b0;
    bit          sawQual = 1'b0;
    bit          prevDone = 1'b0;
    int          phase = 0;
    int          genCount = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compareCount++;
        if (got !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Tick generator plus line monitor: one TXD sample in the middle of every baud period of a frame.
    initial begin
        forever begin
            @(posedge clk);
            sawTick = en_usrt;
            sawQual = en_usrt & RTS;
            @(negedge clk);
            if (sawTick) begin
                phase    = 0;
                lastQual = sawQual;
            end else begin
                phase++;
            end
            if (rst) begin
                capturing = 1'b0;
                prevDone  = 1'b0;
            end else begin
                if (prevDone) checkOutput("doneWidth", 64'(done), 64'd0);
                prevDone = done;
                if (capturing && sawQual) capTicks++;
                if (capturing && done) begin
                    frames.push_back('{capBits, capN, capTicks, TXD, START});
                    capturing = 1'b0;
                end
                if (!capturing && START) begin
                    capturing = 1'b1;
                    capBits   = '0;
                    capN      = 0;
                    capTicks  = 0;
                end
                if (capturing && phase == TICK_GAP / 2) begin
                    if (lastQual) begin
                        if (capN < 64) capBits[capN] = TXD;
                        capN++;
                        lastBit = TXD;
                    end else begin
                        checkOutput("rtsHold", 64'(TXD), 64'(lastBit));
                    end
                end
            end
            genCount++;
            en_usrt = (genCount % TICK_GAP == 0);
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: time limit reached, observed no end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void buildFrame(input logic [27:0] d, input bit par,
                                       output logic [63:0] v, output int n);
        logic [6:0] ch;
        v = '0;
        n = 0;
        for (int c = 0; c < 4; c++) begin
            ch = d[7*c +: 7];
            v[n] = 1'b0;
            n++;
            for (int b = 0; b < 7; b++) begin
                v[n] = ch[b];
                n++;
            end
            if (par) begin
                v[n] = ^ch;
                n++;
            end
            v[n] = 1'b1;
            n++;
        end
    endfunction

    task automatic waitNeg();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [27:0] data);
        int budget = 2000;
        waitNeg();
        wrIf.din   = data;
        wrIf.wr_en = 1'b1;
        while (!wrIf.rdy && budget > 0) begin
            waitNeg();
            budget--;
        end
        checkOutput("acceptRdy", 64'(wrIf.rdy), 64'd1);
        waitNeg();
        wrIf.wr_en = 1'b0;
    endtask

    task automatic waitCout(input int target);
        int budget = 2000;
        while (int'(cout) != target && budget > 0) begin
            waitNeg();
            budget--;
        end
        checkOutput("coutReached", 64'(cout), 64'(target));
    endtask

    task automatic waitFrameArrival();
        int budget = 3000;
        while (frames.size() == 0 && budget > 0) begin
            waitNeg();
            budget--;
        end
        checkOutput("frameDone", 64'(frames.size() > 0), 64'd1);
    endtask

    task automatic checkFrame(input logic [27:0] d, input bit par, input bit chain,
                              output logic [63:0] gotBits);
        logic [63:0] expBits;
        int          expN;
        frameRec_t   f;
        buildFrame(d, par, expBits, expN);
        waitFrameArrival();
        gotBits = '0;
        if (frames.size() > 0) begin
            f = frames.pop_front();
            gotBits = f.bits;
            checkOutput("frameBits", f.bits, expBits);
            checkOutput("frameSlots", 64'(f.nBits), 64'(expN));
            checkOutput("frameTicks", 64'(f.ticks), 64'(expN));
            checkOutput("lineAtEnd", 64'(f.txdAtDone), chain ? 64'd0 : 64'd1);
            checkOutput("startAtEnd", 64'(f.startAtDone), 64'(chain));
        end
    endtask

    task automatic checkIdle();
        checkOutput("idleTxd", 64'(TXD), 64'd1);
        checkOutput("idleStart", 64'(START), 64'd0);
        checkOutput("idleBusy", 64'(busy), 64'd0);
        checkOutput("idleRdy", 64'(wrIf.rdy), 64'd1);
    endtask

    // Freezes the counter for len ticks once it reaches slot target (target%10 in 1..7).
    task automatic pauseRts(input logic [27:0] d, input int target, input int len);
        int k = 0;
        int c = target / 10;
        int s = target % 10;
        waitCout(target);
        RTS = 1'b0;
        while (k < len) begin
            waitNeg();
            if (en_usrt) k++;
        end
        checkOutput("rtsPauseLevel", 64'(TXD), 64'(d[7*c + s - 1]));
        waitNeg();
        RTS = 1'b1;
    endtask

    task automatic runFrame(input logic [27:0] d, input bit par, input int pauseAt, input int pauseLen,
                            output logic [63:0] gotBits);
        par_en = par;
        applyStimulus(d);
        if (pauseAt > 0) pauseRts(d, pauseAt, pauseLen);
        checkFrame(d, par, 1'b0, gotBits);
        checkIdle();
    endtask

    logic [63:0] gotBits;
    logic [27:0] dataA;
    logic [27:0] dataB;
    bit          randPar;
    int          randPause;
    int          randLen;

    initial begin
        wrIf.din   = '0;
        wrIf.wr_en = 1'b0;
        repeat (3) waitNeg();
        checkOutput("rstTxd", 64'(TXD), 64'd1);
        checkOutput("rstStart", 64'(START), 64'd0);
        checkOutput("rstBusy", 64'(busy), 64'd0);
        checkOutput("rstDone", 64'(done), 64'd0);
        checkOutput("rstRdy", 64'(wrIf.rdy), 64'd1);
        rst = 1'b0;
        waitNeg();

        $display("[TB] single frame 0x41 with parity");
        runFrame(28'h0000041, 1'b1, 0, 0, gotBits);
        checkOutput("char0Bits", 64'(gotBits[9:0]), 64'(10'b1010000010));

        $display("[TB] single frame 0x41 without parity");
        runFrame(28'h0000041, 1'b0, 0, 0, gotBits);
        runFrame(28'hFFFFFFF, 1'b1, 0, 0, gotBits);
        runFrame(28'h0000000, 1'b0, 0, 0, gotBits);

        $display("[TB] RTS pause at slot 13");
        dataA = 28'($urandom);
        runFrame(dataA, 1'b1, 13, 5, gotBits);

        $display("[TB] reset mid-frame at slot 22");
        par_en = 1'b1;
        applyStimulus(28'($urandom));
        waitCout(22);
        rst = 1'b1;
        waitNeg();
        checkIdle();
        rst = 1'b0;
        waitNeg();
        runFrame(28'($urandom), 1'b1, 0, 0, gotBits);

`ifdef USRT_TX_HOLD_EN
        $display("[TB] back-to-back frames through the hold buffer");
        dataA  = 28'($urandom);
        dataB  = 28'($urandom);
        par_en = 1'b1;
        applyStimulus(dataA);
        waitCout(3);
        applyStimulus(dataB);
        checkOutput("holdRdyLow", 64'(wrIf.rdy), 64'd0);
        waitFrameArrival();
        checkOutput("holdRdyHigh", 64'(wrIf.rdy), 64'd1);
        checkOutput("chainBusy", 64'(busy), 64'd1);
        checkFrame(dataA, 1'b1, 1'b1, gotBits);
        checkFrame(dataB, 1'b1, 1'b0, gotBits);
        checkIdle();
`else
        $display("[TB] handshake stall while sending");
        dataA  = 28'($urandom);
        dataB  = 28'($urandom);
        par_en = 1'b1;
        applyStimulus(dataA);
        waitCout(3);
        wrIf.din   = dataB;
        wrIf.wr_en = 1'b1;
        waitNeg();
        checkOutput("stallRdyLow", 64'(wrIf.rdy), 64'd0);
        waitFrameArrival();
        checkOutput("stallRdyIdle", 64'(wrIf.rdy), 64'd1);
        checkOutput("stallBusyIdle", 64'(busy), 64'd0);
        waitNeg();
        checkOutput("stallAccepted", 64'(busy), 64'd1);
        wrIf.wr_en = 1'b0;
        checkFrame(dataA, 1'b1, 1'b0, gotBits);
        checkFrame(dataB, 1'b1, 1'b0, gotBits);
        checkIdle();
`endif

        $display("[TB] randomized frames");
        for (int i = 0; i < 8; i++) begin
            dataA     = 28'($urandom);
            randPar   = 1'($urandom_range(0, 1));
            randPause = 0;
            randLen   = 0;
            if ($urandom_range(0, 1) == 1) begin
                randPause = 10 * int'($urandom_range(0, 3)) + int'($urandom_range(1, 7));
                randLen   = int'($urandom_range(1, 5));
            end
            runFrame(dataA, randPar, randPause, randLen, gotBits);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
